// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: system-register address map and interrupt
// gateway state encoding.
package pipeline_pkg;

  typedef enum logic [31:0] {
    SR_IRQ_EN    = 32'h0000_1010,
    SR_IRQ_MODE  = 32'h0000_1011,
    SR_IRQ_PEND  = 32'h0000_1012,
    SR_IRQ_CLAIM = 32'h0000_1013,
    SR_IRQ_DONE  = 32'h0000_1014
  } sreg_e;

  typedef logic [1:0] gw_state_t;

  localparam gw_state_t GW_IDLE = 2'd0;
  localparam gw_state_t GW_PEND = 2'd1;
  localparam gw_state_t GW_BUSY = 2'd2;

endpackage

// File: rtl/irq_ctrl_if.sv
// System-register access bus (mtsr/mfsr) between the pipeline and the
// interrupt controller.
interface irq_ctrl_if;
  logic [31:0] sr_addr;
  logic        sr_re;
  logic        sr_we;
  logic [31:0] sr_wdata;
  logic [31:0] sr_rdata;

  modport master (
    output sr_addr,
    output sr_re,
    output sr_we,
    output sr_wdata,
    input  sr_rdata
  );

  modport slave (
    input  sr_addr,
    input  sr_re,
    input  sr_we,
    input  sr_wdata,
    output sr_rdata
  );
endinterface

// File: rtl/irq_gateway.sv
// Per-source interrupt gateway: IDLE -> PEND -> BUSY, with a sticky latch that
// remembers an edge arriving while the source is being serviced.
module irq_gateway
  import pipeline_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      src_q,
  input  logic      edge_ev,
  input  logic      mode,
  input  logic      claim,
  input  logic      w1c,
  input  logic      done,
  output gw_state_t state
);

  gw_state_t state_q, state_d;
  logic      sticky_q, sticky_d;

  always_comb begin
    state_d  = state_q;
    sticky_d = sticky_q;
    case (state_q)
      GW_IDLE: begin
        if (mode ? edge_ev : src_q) state_d = GW_PEND;
      end
      GW_PEND: begin
        // Claim beats W1C; a fresh edge in the W1C cycle keeps the request.
        if (claim)                           state_d = GW_BUSY;
        else if (!mode && !src_q)            state_d = GW_IDLE;
        else if (mode && w1c && !edge_ev)    state_d = GW_IDLE;
      end
      GW_BUSY: begin
        if (done) begin
          state_d  = (sticky_q || edge_ev) ? GW_PEND : GW_IDLE;
          sticky_d = 1'b0;
        end else if (edge_ev) begin
          sticky_d = 1'b1;
        end
      end
      default: begin
        state_d  = GW_IDLE;
        sticky_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= GW_IDLE;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sticky_q <= sticky_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source gateways, system-register decode, and
// lowest-index-first claim arbitration feeding a registered irq line.
module irq_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned NSRC = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src,
  irq_ctrl_if.slave       sr,
  output logic            irq
);

  logic [NSRC-1:0] src_q, en_q, en_d, mode_q, mode_d;
  logic            irq_q, irq_d;
  gw_state_t       gw_state [NSRC];
  logic [NSRC-1:0] pend_vec, edge_vec, claim_vec, claim_oh, w1c_vec, done_vec;
  logic [31:0]     claim_id;
  logic [31:0]     rdata;
  logic            owned;
  logic            claim_go, en_we, mode_we, pend_we, done_we;
  logic            found;

  assign edge_vec = src & ~src_q;

  assign claim_go = sr.sr_re && (sr.sr_addr == SR_IRQ_CLAIM);
  assign en_we    = sr.sr_we && (sr.sr_addr == SR_IRQ_EN);
  assign mode_we  = sr.sr_we && (sr.sr_addr == SR_IRQ_MODE);
  assign pend_we  = sr.sr_we && (sr.sr_addr == SR_IRQ_PEND);
  assign done_we  = sr.sr_we && (sr.sr_addr == SR_IRQ_DONE);

  always_comb begin
    for (int i = 0; i < int'(NSRC); i++) begin
      pend_vec[i] = (gw_state[i] == GW_PEND);
    end
  end

  // Lowest-index enabled pending source wins the claim.
  always_comb begin
    found    = 1'b0;
    claim_id = '0;
    claim_oh = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      if (!found && pend_vec[i] && en_q[i]) begin
        found       = 1'b1;
        claim_id    = 32'(i + 1);
        claim_oh[i] = 1'b1;
      end
    end
  end

  assign claim_vec = claim_go ? claim_oh : '0;
  assign w1c_vec   = pend_we ? sr.sr_wdata[NSRC-1:0] : '0;

  // Out-of-range ids never match; non-BUSY targets are ignored by the gateway.
  always_comb begin
    for (int i = 0; i < int'(NSRC); i++) begin
      done_vec[i] = done_we && (sr.sr_wdata == 32'(i + 1));
    end
  end

  always_comb begin
    en_d   = en_we ? sr.sr_wdata[NSRC-1:0] : en_q;
    mode_d = mode_q;
    for (int i = 0; i < int'(NSRC); i++) begin
      if (mode_we && gw_state[i] == GW_IDLE) mode_d[i] = sr.sr_wdata[i];
    end
  end

  // A source claimed this cycle no longer contributes to the request.
  assign irq_d = |(pend_vec & en_q & ~claim_vec);

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q  <= '0;
      en_q   <= '0;
      mode_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      src_q  <= src;
      en_q   <= en_d;
      mode_q <= mode_d;
      irq_q  <= irq_d;
    end
  end

  for (genvar g = 0; g < int'(NSRC); g++) begin : g_gw
    irq_gateway u_gw (
      .clk     (clk),
      .rst     (rst),
      .src_q   (src_q[g]),
      .edge_ev (edge_vec[g]),
      .mode    (mode_q[g]),
      .claim   (claim_vec[g]),
      .w1c     (w1c_vec[g]),
      .done    (done_vec[g]),
      .state   (gw_state[g])
    );
  end

  always_comb begin
    rdata = '0;
    owned = 1'b1;
    case (sr.sr_addr)
      SR_IRQ_EN:    rdata = 32'(en_q);
      SR_IRQ_MODE:  rdata = 32'(mode_q);
      SR_IRQ_PEND:  rdata = 32'(pend_vec);
      SR_IRQ_CLAIM: rdata = claim_id;
      SR_IRQ_DONE:  rdata = '0;
      default:      owned = 1'b0;
    endcase
  end

  assign sr.sr_rdata = owned ? rdata : 'z;
  assign irq         = irq_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus randomized traffic,
// all compared against a per-source behavioural model.
module tb_irq_ctrl;
  import pipeline_pkg::*;

  localparam int unsigned NSRC = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NSRC-1:0] src;
  logic            irq;

  irq_ctrl_if bus ();

  irq_ctrl #(.NSRC(NSRC)) dut (
    .clk (clk),
    .rst (rst),
    .src (src),
    .sr  (bus.slave),
    .irq (irq)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          chk_en   = 1'b0;
  logic [31:0] last_rd;
  logic [31:0] d;

  // Model: each source is idle, pending, or in service.
  bit [NSRC-1:0] m_pend, m_busy, m_sticky, m_en, m_mode, m_srcq;
  bit            m_irq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_claim_id();
    for (int i = 0; i < int'(NSRC); i++) if (m_pend[i] && m_en[i]) return i + 1;
    return 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    case (a)
      SR_IRQ_EN:    return 32'(m_en);
      SR_IRQ_MODE:  return 32'(m_mode);
      SR_IRQ_PEND:  return 32'(m_pend);
      SR_IRQ_CLAIM: return 32'(m_claim_id());
      default:      return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    bit [NSRC-1:0] n_pend, n_busy, n_sticky, n_mode;
    int cid, did;
    bit ev, w1c;
    if (rst) begin
      m_pend = '0; m_busy = '0; m_sticky = '0; m_en = '0; m_mode = '0; m_srcq = '0;
      m_irq = 1'b0;
      return;
    end
    cid = (bus.sr_re && bus.sr_addr == SR_IRQ_CLAIM) ? m_claim_id() : 0;
    did = (bus.sr_we && bus.sr_addr == SR_IRQ_DONE) ? int'(bus.sr_wdata) : 0;
    n_pend = m_pend; n_busy = m_busy; n_sticky = m_sticky; n_mode = m_mode;
    m_irq = 1'b0;
    for (int i = 0; i < int'(NSRC); i++) begin
      ev  = src[i] && !m_srcq[i];
      w1c = bus.sr_we && bus.sr_addr == SR_IRQ_PEND && bus.sr_wdata[i];
      if (m_pend[i] && m_en[i] && cid != i + 1) m_irq = 1'b1;
      if (m_busy[i]) begin
        if (did == i + 1) begin
          n_busy[i] = 1'b0;
          n_pend[i] = m_sticky[i] || ev;
          n_sticky[i] = 1'b0;
        end else if (ev) begin
          n_sticky[i] = 1'b1;
        end
      end else if (m_pend[i]) begin
        if (cid == i + 1) begin
          n_pend[i] = 1'b0;
          n_busy[i] = 1'b1;
        end else if (!m_mode[i] && !m_srcq[i]) begin
          n_pend[i] = 1'b0;
        end else if (m_mode[i] && w1c && !ev) begin
          n_pend[i] = 1'b0;
        end
      end else begin
        if (m_mode[i] ? ev : m_srcq[i]) n_pend[i] = 1'b1;
        if (bus.sr_we && bus.sr_addr == SR_IRQ_MODE) n_mode[i] = bus.sr_wdata[i];
      end
    end
    if (bus.sr_we && bus.sr_addr == SR_IRQ_EN) m_en = bus.sr_wdata[NSRC-1:0];
    m_pend = n_pend; m_busy = n_busy; m_sticky = n_sticky; m_mode = n_mode;
    m_srcq = src;
  endtask

  // One clock: compare outputs mid-cycle, advance, update the model.
  task automatic tick();
    #1;
    if (chk_en) check("irq", 32'(irq), 32'(m_irq));
    if (bus.sr_re && !rst) begin
      last_rd = bus.sr_rdata;
      check("rdata", bus.sr_rdata, m_read(bus.sr_addr));
    end
    @(posedge clk);
    model_step();
    #1;
    bus.sr_re = 1'b0;
    bus.sr_we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] v);
    bus.sr_addr  = a;
    bus.sr_wdata = v;
    bus.sr_we    = 1'b1;
    tick();
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    bus.sr_addr = a;
    bus.sr_re   = 1'b1;
    tick();
    v = last_rd;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src = '0;
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic wait_irq(input int budget, input string tag);
    int n = 0;
    while (irq !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(irq), 32'h1);
  endtask

  task automatic pulse(input logic [NSRC-1:0] v);
    src = v;
    tick();
    src = '0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; src = '0;
    bus.sr_addr = '0; bus.sr_re = 1'b0; bus.sr_we = 1'b0; bus.sr_wdata = '0;
    @(posedge clk);
    #1;
    do_reset();
    check("rst_irq", 32'(irq), 32'h0);
    rd(SR_IRQ_PEND, d);  check("rst_pend", d, 32'h0);
    rd(SR_IRQ_EN, d);    check("rst_en", d, 32'h0);

    // Level source 2, claim, service, re-assert while still high.
    wr(SR_IRQ_EN, 32'h05);
    src = 8'h04;
    wait_irq(4, "lvl_irq");
    rd(SR_IRQ_CLAIM, d); check("lvl_claim", d, 32'd3);
    check("lvl_irq_drop", 32'(irq), 32'h0);
    wr(SR_IRQ_DONE, 32'd3);
    wait_irq(4, "lvl_reassert");
    src = '0;
    tick(); tick(); tick();

    // Two simultaneous edges are claimed in index order.
    do_reset();
    wr(SR_IRQ_MODE, 32'hFF); wr(SR_IRQ_EN, 32'hFF);
    pulse(8'h42);
    rd(SR_IRQ_CLAIM, d); check("edge_claim_a", d, 32'd2);
    rd(SR_IRQ_CLAIM, d); check("edge_claim_b", d, 32'd7);
    rd(SR_IRQ_CLAIM, d); check("edge_claim_c", d, 32'd0);

    // Edge during service is remembered until DONE.
    do_reset();
    wr(SR_IRQ_MODE, 32'h01); wr(SR_IRQ_EN, 32'h01);
    pulse(8'h01); tick();
    rd(SR_IRQ_CLAIM, d); check("sticky_claim1", d, 32'd1);
    pulse(8'h01); tick();
    check("sticky_irq_low", 32'(irq), 32'h0);
    wr(SR_IRQ_DONE, 32'd1);
    wait_irq(4, "sticky_irq");
    rd(SR_IRQ_CLAIM, d); check("sticky_claim2", d, 32'd1);

    // Masked source stays pending but invisible.
    do_reset();
    wr(SR_IRQ_MODE, 32'h04);
    pulse(8'h04); tick();
    check("mask_irq", 32'(irq), 32'h0);
    rd(SR_IRQ_CLAIM, d); check("mask_claim", d, 32'd0);
    rd(SR_IRQ_PEND, d);  check("mask_pend", d, 32'h04);
    wr(SR_IRQ_EN, 32'h04);
    wait_irq(2, "unmask_irq");

    // W1C racing a new edge, and DONE naming an idle source.
    do_reset();
    wr(SR_IRQ_MODE, 32'hFF); wr(SR_IRQ_EN, 32'hFF);
    pulse(8'h08);
    rd(SR_IRQ_PEND, d);  check("w1c_pre", d, 32'h08);
    src = 8'h08;
    wr(SR_IRQ_PEND, 32'h08);
    src = '0;
    rd(SR_IRQ_PEND, d);  check("w1c_race", d, 32'h08);
    wr(SR_IRQ_DONE, 32'd5);
    rd(SR_IRQ_PEND, d);  check("done_idle", d, 32'h08);
    wr(SR_IRQ_PEND, 32'h08);
    rd(SR_IRQ_PEND, d);  check("w1c_clear", d, 32'h00);

    // Reset discards in-service and pending state.
    do_reset();
    wr(SR_IRQ_MODE, 32'hFF); wr(SR_IRQ_EN, 32'hFF);
    pulse(8'h02);
    rd(SR_IRQ_CLAIM, d); check("rst_mid_claim", d, 32'd2);
    pulse(8'h04);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_irq", 32'(irq), 32'h0);
    rd(SR_IRQ_PEND, d);  check("rst_mid_pend", d, 32'h0);
    rd(SR_IRQ_CLAIM, d); check("rst_mid_claim0", d, 32'd0);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 2) == 0) src = src ^ NSRC'($urandom() & $urandom());
      case ($urandom_range(0, 11))
        0: begin bus.sr_we = 1'b1; bus.sr_addr = SR_IRQ_EN;   bus.sr_wdata = $urandom(); end
        1: begin bus.sr_we = 1'b1; bus.sr_addr = SR_IRQ_MODE; bus.sr_wdata = $urandom(); end
        2: begin bus.sr_we = 1'b1; bus.sr_addr = SR_IRQ_PEND; bus.sr_wdata = $urandom(); end
        3, 4: begin
          bus.sr_we = 1'b1; bus.sr_addr = SR_IRQ_DONE; bus.sr_wdata = $urandom_range(0, 10);
        end
        5, 6, 7: begin bus.sr_re = 1'b1; bus.sr_addr = SR_IRQ_CLAIM; end
        8: begin bus.sr_re = 1'b1; bus.sr_addr = SR_IRQ_PEND; end
        9: begin bus.sr_re = 1'b1; bus.sr_addr = ($urandom_range(0, 1) == 0) ? SR_IRQ_EN : SR_IRQ_MODE; end
        default: ;
      endcase
      tick();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
